// File: rtl/sorter_pkg.sv
// ---------------------------------------------------------------------------
// sorter_pkg
// Shared constant functions for the bitonic sorter pipeline:
//   log2_int     - integer log2 of a power of two (ceil for others)
//   stage_count  - number of compare-exchange stages for N elements
//   stage_k      - bitonic block size k used by stage s
//   stage_j      - compare distance j used by stage s
//   pair_lo      - lower element index of comparator p in stage s
//   pair_desc    - 1 when comparator p of stage s orders its pair descending
//                  (for an ascending overall sort; the vector's desc bit
//                  inverts every comparator)
// ---------------------------------------------------------------------------
package sorter_pkg;

   function automatic int log2_int(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

   function automatic int stage_count(input int n);
      int l;
      l = log2_int(n);
      return (l * (l + 1)) / 2;
   endfunction

   // Stages enumerate the classic bitonic loop nest: k = 2,4..N outer,
   // j = k/2 down to 1 inner. Stage s is the s-th (k, j) pair.
   function automatic int stage_k(input int n, input int s);
      int cnt;
      int res;
      cnt = 0;
      res = 0;
      for (int k = 2; k <= n; k = k * 2) begin
         for (int j = k / 2; j >= 1; j = j / 2) begin
            if (cnt == s) res = k;
            cnt = cnt + 1;
         end
      end
      return res;
   endfunction

   function automatic int stage_j(input int n, input int s);
      int cnt;
      int res;
      cnt = 0;
      res = 0;
      for (int k = 2; k <= n; k = k * 2) begin
         for (int j = k / 2; j >= 1; j = j / 2) begin
            if (cnt == s) res = j;
            cnt = cnt + 1;
         end
      end
      return res;
   endfunction

   // Comparators of a stage pair element i with i ^ j where bit j of i is 0;
   // the p-th such i is found by splitting p into block and offset.
   function automatic int pair_lo(input int n, input int s, input int p);
      int j;
      j = stage_j(n, s);
      return ((p / j) * 2 * j) + (p % j);
   endfunction

   function automatic bit pair_desc(input int n, input int s, input int p);
      int k;
      int lo;
      k  = stage_k(n, s);
      lo = pair_lo(n, s, p);
      return ((lo & k) != 0);
   endfunction

endpackage

// File: rtl/sorter_pipe_if.sv
// ---------------------------------------------------------------------------
// sorter_pipe_if
// Handshake bundle for the sorter pipeline.
//   in_valid/in_ready/in_data/in_desc   - input vector stream
//   out_valid/out_ready/out_data/out_desc - sorted output stream
//   busy                                 - pipeline holds a valid vector
// Modports: master = producer/consumer side, slave = the sorter.
// ---------------------------------------------------------------------------
interface sorter_pipe_if #(
   parameter int W = 8,
   parameter int N = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [N-1:0][W-1:0] in_data;
   logic                in_desc;
   logic                out_valid;
   logic                out_ready;
   logic [N-1:0][W-1:0] out_data;
   logic                out_desc;
   logic                busy;

   modport master (
      output in_valid, in_data, in_desc, out_ready,
      input  in_ready, out_valid, out_data, out_desc, busy
   );

   modport slave (
      input  in_valid, in_data, in_desc, out_ready,
      output in_ready, out_valid, out_data, out_desc, busy
   );
endinterface

// File: rtl/sorter_pipe_cmp_swap.sv
// ---------------------------------------------------------------------------
// cmp_swap
// Combinational W-bit compare-exchange.
//   a_in, b_in - pair entering the comparator (a = lower index)
//   dir        - 0: lo_out gets the smaller, 1: lo_out gets the larger
//   lo_out, hi_out - ordered pair
// Compare is strict, so equal elements pass through unswapped.
// ---------------------------------------------------------------------------
module cmp_swap #(
   parameter int W          = 8,
   parameter int SIGNED_CMP = 0
) (
   input  logic [W-1:0] a_in,
   input  logic [W-1:0] b_in,
   input  logic         dir,
   output logic [W-1:0] lo_out,
   output logic [W-1:0] hi_out
);
   logic a_gt_b;
   logic b_gt_a;
   logic swap;

   always_comb begin
      if (SIGNED_CMP != 0) begin
         a_gt_b = $signed(a_in) > $signed(b_in);
         b_gt_a = $signed(b_in) > $signed(a_in);
      end else begin
         a_gt_b = a_in > b_in;
         b_gt_a = b_in > a_in;
      end
      swap   = dir ? b_gt_a : a_gt_b;
      lo_out = swap ? b_in : a_in;
      hi_out = swap ? a_in : b_in;
   end
endmodule

// File: rtl/sorter_pipe.sv
// ---------------------------------------------------------------------------
// sorter_pipe
// Pipelined bitonic sorter: one register bank per compare-exchange stage,
// each bank carrying its own valid and desc bit so vectors of either sort
// direction can share the pipeline.
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - sorter_pipe_if.slave: input/output streams and busy
// All banks advance together whenever the output is not stalled, so in_ready
// is simply that advance enable.
// ---------------------------------------------------------------------------
module sorter_pipe
   import sorter_pkg::*;
#(
   parameter int W          = 8,
   parameter int N          = 8,
   parameter int SIGNED_CMP = 0
) (
   input logic          clk,
   input logic          reset,
   sorter_pipe_if.slave bus
);
   localparam int S = stage_count(N);

   typedef logic [N-1:0][W-1:0] vec_t;

   vec_t data_reg  [S];
   logic valid_reg [S];
   logic desc_reg  [S];

   vec_t stage_in   [S];
   logic stage_desc [S];
   vec_t stage_out  [S];

   logic adv;
   logic busy_w;

   assign adv = !(valid_reg[S-1] && !bus.out_ready);

   generate
      for (genvar gi = 0; gi < S; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign stage_in[gi]   = bus.in_data;
            assign stage_desc[gi] = bus.in_desc;
         end else begin : g_next
            assign stage_in[gi]   = data_reg[gi-1];
            assign stage_desc[gi] = desc_reg[gi-1];
         end

         for (genvar gj = 0; gj < N / 2; gj++) begin : g_pair
            localparam int LO    = pair_lo(N, gi, gj);
            localparam int HI    = LO + stage_j(N, gi);
            localparam bit DDESC = pair_desc(N, gi, gj);

            // A descending vector mirrors every comparator direction.
            cmp_swap #(
               .W          (W),
               .SIGNED_CMP (SIGNED_CMP)
            ) u_cmp (
               .a_in   (stage_in[gi][LO]),
               .b_in   (stage_in[gi][HI]),
               .dir    (stage_desc[gi] ^ DDESC),
               .lo_out (stage_out[gi][LO]),
               .hi_out (stage_out[gi][HI])
            );
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < S; s++) begin
            valid_reg[s] <= 1'b0;
            desc_reg[s]  <= 1'b0;
            data_reg[s]  <= '0;
         end
      end else if (adv) begin
         // Stage 0 takes in_valid directly: a missing input becomes a bubble.
         valid_reg[0] <= bus.in_valid;
         desc_reg[0]  <= stage_desc[0];
         data_reg[0]  <= stage_out[0];
         for (int s = 1; s < S; s++) begin
            valid_reg[s] <= valid_reg[s-1];
            desc_reg[s]  <= stage_desc[s];
            data_reg[s]  <= stage_out[s];
         end
      end
   end

   always_comb begin
      busy_w = 1'b0;
      for (int s = 0; s < S; s++) busy_w = busy_w | valid_reg[s];
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = valid_reg[S-1];
   assign bus.out_data  = data_reg[S-1];
   assign bus.out_desc  = desc_reg[S-1];
   assign bus.busy      = busy_w;
endmodule

// File: doc/sorter_pipe.md
SORTER_PIPE -- requirements
Module: sorter_pipe

Interface
REQ-001 SHALL have parameter W, default 8: element width in bits, legal 2..32.
REQ-002 SHALL have parameter N, default 8: elements per vector, a power of two, legal 2..16.
REQ-003 SHALL have parameter SIGNED_CMP, default 0: 0 compares unsigned, 1 compares two's-complement.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data and in_desc are presented.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a vector this cycle.
REQ-008 SHALL have port in_data, input, N x W: unsorted vector, element 0 to N-1.
REQ-009 SHALL have port in_desc, input, 1 bit: 1 sorts descending (element 0 = max); 0 sorts ascending.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a sorted vector.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes out_data this cycle.
REQ-012 SHALL have port out_data, output, N x W: sorted vector.
REQ-013 SHALL have port out_desc, output, 1 bit: the in_desc value that travelled with this vector.
REQ-014 SHALL have port busy, output, 1 bit: at least one pipeline stage holds a valid vector.

Function
REQ-015 SHALL implement a bitonic sorting network of S = log2(N)*(log2(N)+1)/2 compare-exchange stages (S=6 for N=8), with one register bank per stage.
REQ-016 SHALL carry a valid bit and the desc bit with every stage register, so vectors with different modes coexist in the pipeline.
REQ-017 SHALL accept a vector when in_valid && in_ready on a rising edge.
REQ-018 SHALL advance all stages together under a single enable: adv = !(out_valid && !out_ready).
REQ-019 SHALL drive in_ready = adv (combinational); it SHALL NOT depend on in_valid.
REQ-020 SHALL present an accepted vector on out_valid exactly S cycles after acceptance, provided adv holds in every intervening cycle; each stalled cycle adds one cycle.
REQ-021 SHALL sustain one vector per cycle when out_ready is held high.
REQ-022 SHALL hold out_data, out_desc and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL insert a bubble (valid=0) into stage 1 when adv && !in_valid; bubbles never raise out_valid.
REQ-024 SHALL make out_data a permutation of the accepted in_data; duplicates are preserved in count, and tie ordering is unobservable.
REQ-025 SHALL use a strict compare (a > b) per SIGNED_CMP on each comparator; equal elements pass unswapped.
REQ-026 SHALL assert busy = OR of all stage valid bits, registered with them.
REQ-027 SHALL NOT lose or duplicate a vector when in_valid, out_valid and !out_ready coincide: the input is refused (in_ready=0) and the source retries.

Reset
REQ-028 SHALL, while reset=1, asynchronously clear all stage valid bits, desc bits and data registers to 0, giving out_valid=0, out_data=0, out_desc=0, busy=0 and in_ready=1.
REQ-029 SHALL discard any in-flight vectors on a reset asserted mid-operation; the first vector accepted after reset deasserts emerges S cycles later.

Structure
REQ-030 SHALL place in package sorter_pkg: the function stage_count(N), the function log2 helper, and the compare-exchange index/direction tables as constant functions.
REQ-031 SHALL use one sub-module, cmp_swap, a combinational W-bit compare-exchange with dir and SIGNED_CMP inputs, instantiated N/2 times per stage.

Verification
REQ-032 SHALL cover the following directed scenario: N=8, desc=1, in {3,200,7,7,0,255,18,1} -> {255,200,18,7,7,3,1,0} with out_valid exactly 6 cycles after accept.
REQ-033 SHALL cover the following directed scenario: back-to-back vectors alternating desc=1/0 with out_ready=1 -> one output per cycle, each sorted per its own out_desc.
REQ-034 SHALL cover the following directed scenario: out_ready=0 for 4 cycles while a full pipeline is present -> in_ready=0, out_data frozen, then 6 vectors drain in order with none lost.
REQ-035 SHALL cover the following directed scenario: SIGNED_CMP=1, ascending, in {0x80,0x7F,0x00,0xFF,...} -> -128 first, 127 last; SIGNED_CMP=0 with the same data -> 0x00 first.
REQ-036 SHALL cover the following directed scenario: reset asserted with 3 vectors in flight -> out_valid and busy fall immediately and no stale vector appears afterwards.
REQ-037 SHALL cover the following directed scenario: a random run of 10k vectors under random in_valid/out_ready, compared against a scoreboard sort model -> zero mismatches.
